// File: rtl/gate_equiv_sequencer.sv
// Sweeps every input vector through two implementations of a function and compares them,
// capturing both truth tables, the mismatch count and the lowest failing minterm.
module gate_equiv_sequencer #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sa,
    input  logic                 sb,
    output logic [N_IN-1:0]      x_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail,
    output logic [2**N_IN-1:0]   tt_a,
    output logic [2**N_IN-1:0]   tt_b
);

    localparam int               NT          = 2**N_IN;
    localparam logic [N_IN-1:0]  X_LAST      = {N_IN{1'b1}};
    localparam logic [N_IN:0]    CNT_MAX     = (N_IN+1)'(NT);
    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE-1);

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

    state_t              state_q;
    logic [N_IN-1:0]     x_q;
    logic [3:0]          settle_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [N_IN:0]       mcnt_q;
    logic [N_IN:0]       mcnt_d;
    logic [N_IN-1:0]     ff_q;
    logic [NT-1:0]       tta_q;
    logic [NT-1:0]       ttb_q;

    assign mcnt_d = (mcnt_q == CNT_MAX) ? mcnt_q : mcnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            mcnt_q   <= '0;
            ff_q     <= '0;
            tta_q    <= '0;
            ttb_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q  <= S_DRIVE;
                        x_q      <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        mcnt_q   <= '0;
                        ff_q     <= '0;
                        tta_q    <= '0;
                        ttb_q    <= '0;
                    end
                end
                S_DRIVE: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (settle_q == SETTLE_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        settle_q <= settle_q + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    // abort wins: the minterm under test is dropped, not recorded
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        tta_q[x_q] <= sa;
                        ttb_q[x_q] <= sb;
                        if (sa != sb) begin
                            mcnt_q <= mcnt_d;
                            if (mcnt_q == '0) ff_q <= x_q;
                        end
                        if (x_q == X_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q  <= S_DRIVE;
                            x_q      <= x_q + 1'b1;
                            settle_q <= '0;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    pass_q  <= (mcnt_q == '0);
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign x_out        = x_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign mismatch_cnt = mcnt_q;
    assign first_fail   = ff_q;
    assign tt_a         = tta_q;
    assign tt_b         = ttb_q;

endmodule

// File: doc/gate_equiv_sequencer.md
GATE_EQUIV_SEQUENCER -- requirements
Module: gate_equiv_sequencer

Interface
REQ-001 Parameter N_IN, default 2, number of function inputs driven (legal 1..4).
REQ-002 Parameter SETTLE, default 1, cycles each input vector is held before sampling (legal 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request a full truth-table sweep; sampled only in IDLE.
REQ-006 abort  input  1  terminate a sweep in progress.
REQ-007 sa  input  1  output of implementation A (gate form) under test.
REQ-008 sb  input  1  output of implementation B (expression form) under test.
REQ-009 x_out  output  N_IN  input vector driven to both implementations; x_out[N_IN-1] is the MSB variable ('a' for N_IN=2).
REQ-010 busy  output  1  high in DRIVE and SAMPLE states.
REQ-011 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-012 pass  output  1  high when the last completed sweep had zero mismatches.
REQ-013 mismatch_cnt  output  N_IN+1  count of minterms where sa != sb.
REQ-014 first_fail  output  N_IN  lowest minterm index with sa != sb; 0 when none.
REQ-015 tt_a  output  2**N_IN  captured truth table of sa; bit m = sa at minterm m.
REQ-016 tt_b  output  2**N_IN  captured truth table of sb; bit m = sb at minterm m.

Function
REQ-017 FSM states: IDLE, DRIVE, SAMPLE, DONE.
REQ-018 IDLE with start=1 -> DRIVE; x_out=0, settle counter=0, mismatch_cnt, first_fail, tt_a, tt_b and pass cleared.
REQ-019 DRIVE holds x_out for exactly SETTLE cycles, then -> SAMPLE.
REQ-020 SAMPLE is one cycle; at its closing edge: tt_a[x_out]<=sa, tt_b[x_out]<=sb; on sa!=sb, mismatch_cnt increments, and first_fail<=x_out if this is the first mismatch of the sweep.
REQ-021 SAMPLE with x_out < 2**N_IN-1 -> DRIVE with x_out+1 and settle counter=0; with x_out = 2**N_IN-1 -> DONE, x_out unchanged.
REQ-022 DONE is one cycle: done=1, pass<=(final mismatch_cnt==0), then -> IDLE.
REQ-023 Latency: start accepted at edge k -> done high in the cycle after edge k + 2**N_IN*(SETTLE+1).
REQ-024 x_out never wraps; at most 2**N_IN vectors are applied per sweep.
REQ-025 mismatch_cnt saturates at 2**N_IN; its width makes overflow impossible.
REQ-026 start while busy or in DONE is ignored; no sweep is queued.
REQ-027 abort in DRIVE or SAMPLE -> IDLE at next edge; done not pulsed; pass=0; partial tt_a, tt_b, mismatch_cnt held.
REQ-028 abort and start both high in IDLE: abort wins; state stays IDLE.
REQ-029 abort takes priority over the SAMPLE update in the same cycle; that minterm is not recorded.
REQ-030 Results hold stable in IDLE until the next accepted start.

Reset
REQ-031 rst_n low forces IDLE immediately, independent of clk: x_out=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail=0, tt_a=0, tt_b=0.
REQ-032 Reset asserted mid-sweep discards the sweep; no done pulse follows rst_n release.
REQ-033 First start is honoured at the first rising edge after rst_n goes high.

Verification
REQ-034 N_IN=2, SETTLE=1, sa=a'.b, sb=~a|~b, start pulse -> done 8 cycles later; tt_a=0010, tt_b=0111, mismatch_cnt=2, first_fail=0, pass=0.
REQ-035 Same setup, sb=a'.b -> tt_a=tt_b=0010, mismatch_cnt=0, first_fail=0, pass=1.
REQ-036 SETTLE=3, N_IN=2 -> each x_out value held 4 cycles, sequence 00,01,10,11; done 16 cycles after start.
REQ-037 abort asserted during second SAMPLE (x_out=01) -> IDLE next edge, no done, mismatch_cnt reflects minterm 0 only, pass=0.
REQ-038 start re-pulsed while busy -> sweep length unchanged, exactly one done pulse.
REQ-039 rst_n pulled low mid-DRIVE between clock edges -> all outputs zero without waiting for clk; no done after release.
